// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Widest operand the sign helpers support; wider builds need a larger value.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Two's-complement negate when neg is set. Callers truncate the result
  // to their own width. Negation modulo 2^64 truncates to negation modulo 2^WIDTH.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x,
                                                input logic             neg);
    return neg ? (~x + MAX_W'(1)) : x;
  endfunction

  // Magnitude of a sign-extended operand. For the most negative WIDTH-bit
  // value the low WIDTH bits hold 2^(WIDTH-1) as an unsigned number.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x);
    return cond_neg(x, x[MAX_W-1]);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor magnitude, and keep the result if it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  // Two guard bits: the shifted remainder stays below 2*M, so the sign of
  // the trial difference is exact.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Trial subtract and restore-or-keep selection.
  always_comb begin
    shifted = {p_in, q_msb};
    trial   = shifted - {2'b00, m};
    q_bit   = ~trial[WIDTH+1];
    p_out   = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider that truncates toward zero and retires one
// quotient bit per clock. It uses a start/done handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int               CNT_W   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_p;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p_q),
    .q_msb (q_q[WIDTH-1]),
    .m     (m_q),
    .p_out (step_p),
    .q_bit (step_bit)
  );

  // Next-state logic: accept, iterate, then apply signs and publish the results.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    p_d        = p_q;
    q_d        = q_q;
    m_d        = m_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    zero_d     = zero_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            q_d        = WIDTH'(abs_val(MAX_W'($signed(dividend))));
            m_d        = WIDTH'(abs_val(MAX_W'($signed(divisor))));
            p_d        = '0;
            q_neg_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_d    = dividend[WIDTH-1];
            zero_d     = 1'b0;
            ovf_pend_d = (dividend == MIN_VAL) && (divisor == '1);
            count_d    = CNT_W'(WIDTH);
            state_d    = CALC;
          end else begin
            // The raw dividend rides in Q so it can be returned as the remainder.
            q_d        = dividend;
            zero_d     = 1'b1;
            ovf_pend_d = 1'b0;
            state_d    = FIX;
          end
        end
      end
      CALC: begin
        p_d     = step_p;
        q_d     = {q_q[WIDTH-2:0], step_bit};
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = q_q;
          dbz_d  = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          // Most-negative / -1 lands on 2^(WIDTH-1) unnegated, which is the wrapped quotient.
          quot_d = WIDTH'(cond_neg(MAX_W'(q_q), q_neg_q));
          rem_d  = WIDTH'(cond_neg(MAX_W'(p_q[WIDTH-1:0]), r_neg_q));
          dbz_d  = 1'b0;
          ovf_d  = ovf_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any divide in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every flop is reset here, including the operand registers, so an
      // aborted divide leaves no stale state behind.
      state_q    <= IDLE;
      count_q    <= '0;
      p_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      zero_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so all flops update from the same pre-edge values.
      state_q    <= state_d;
      count_q    <= count_d;
      p_q        <= p_d;
      q_q        <= q_d;
      m_q        <= m_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      zero_q     <= zero_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign ovf         = ovf_q;

endmodule
